// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - operation/result handshake bundle for multicycle_alu
interface multicycle_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch;
  logic            illegal;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, branch, illegal
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, branch, illegal
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multi-cycle ALU: 1-cycle ALU/branch, 2-cycle multiply, iterative divide
// Define ALU_DIV_EN to build the restoring divider; without it ops 21-24 decode as illegal.
module multicycle_alu #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave alu
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8, OP_AND = 5'd9, OP_BEQ = 5'd10, OP_BNE = 5'd11;
  localparam logic [4:0] OP_BLT = 5'd12, OP_BGE = 5'd13, OP_BLTU = 5'd14, OP_BGEU = 5'd15;
  localparam logic [4:0] OP_JAL = 5'd16, OP_MUL = 5'd17, OP_MULH = 5'd18;
  localparam logic [4:0] OP_MULHSU = 5'd19, OP_MULHU = 5'd20;
`ifdef ALU_DIV_EN
  localparam logic [4:0] OP_DIV = 5'd21, OP_DIVU = 5'd22, OP_REM = 5'd23, OP_REMU = 5'd24;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            r_state, w_next;
  logic              w_accept, w_is_mul, w_br, w_ill;
  logic [XLEN-1:0]   w_res;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   r_result;
  logic              r_branch, r_illegal;
  logic [4:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b;
  logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign alu.in_ready  = (r_state == IDLE) || ((r_state == DONE) && alu.out_ready);
  assign alu.out_valid = (r_state == DONE);
  assign alu.result    = r_result;
  assign alu.branch    = r_branch;
  assign alu.illegal   = r_illegal;
  assign w_accept      = alu.in_valid && alu.in_ready && !alu.flush;
  assign w_shamt       = alu.b[SHW-1:0];

`ifdef ALU_DIV_EN
  logic [XLEN-1:0] r_dvd, r_dvs, r_rem;
  logic [SHW-1:0]  r_cnt;
  logic            r_neg_q, r_neg_r, r_is_rem;
  logic            w_is_div, w_div_signed, w_neg_a, w_neg_b, w_ge, w_last;
  logic [XLEN:0]   w_shift, w_diff;
  logic [XLEN-1:0] w_q_n, w_rem_n, w_div_res;

  assign w_div_signed = (alu.op == OP_DIV) || (alu.op == OP_REM);
  assign w_neg_a      = w_div_signed && alu.a[XLEN-1];
  assign w_neg_b      = w_div_signed && alu.b[XLEN-1];
  // Restoring step: r_dvd shifts out dividend bits while quotient bits shift in at the LSB.
  assign w_shift      = {r_rem, r_dvd[XLEN-1]};
  assign w_diff       = w_shift - {1'b0, r_dvs};
  assign w_ge         = !w_diff[XLEN];
  assign w_rem_n      = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_q_n        = {r_dvd[XLEN-2:0], w_ge};
  assign w_div_res    = r_is_rem ? (r_neg_r ? -w_rem_n : w_rem_n) : (r_neg_q ? -w_q_n : w_q_n);
  assign w_last       = (r_cnt == SHW'(XLEN-1));
`endif

  always_comb begin
    w_res    = '0;
    w_br     = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
`ifdef ALU_DIV_EN
    w_is_div = 1'b0;
`endif
    case (alu.op)
      OP_ADD:  w_res = alu.a + alu.b;
      OP_SUB:  w_res = alu.a - alu.b;
      OP_SLL:  w_res = alu.a << w_shamt;
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(alu.a) < $signed(alu.b))};
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, (alu.a < alu.b)};
      OP_XOR:  w_res = alu.a ^ alu.b;
      OP_SRL:  w_res = alu.a >> w_shamt;
      OP_SRA:  w_res = $signed(alu.a) >>> w_shamt;
      OP_OR:   w_res = alu.a | alu.b;
      OP_AND:  w_res = alu.a & alu.b;
      OP_BEQ:  w_br = (alu.a == alu.b);
      OP_BNE:  w_br = (alu.a != alu.b);
      OP_BLT:  w_br = ($signed(alu.a) < $signed(alu.b));
      OP_BGE:  w_br = ($signed(alu.a) >= $signed(alu.b));
      OP_BLTU: w_br = (alu.a < alu.b);
      OP_BGEU: w_br = (alu.a >= alu.b);
      OP_JAL: begin
        w_res = alu.a + alu.b;
        w_br  = 1'b1;
      end
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_is_mul = 1'b1;
`ifdef ALU_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
        // Zero divisor and signed overflow resolve immediately without iterating.
        if (alu.b == '0)
          w_res = ((alu.op == OP_DIV) || (alu.op == OP_DIVU)) ? '1 : alu.a;
        else if (w_div_signed && (alu.a == {1'b1, {(XLEN-1){1'b0}}}) && (alu.b == '1))
          w_res = (alu.op == OP_DIV) ? alu.a : '0;
        else
          w_is_div = 1'b1;
      end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Both operands extended to 2*XLEN so a modular product yields the exact full-width result.
  assign w_ma      = {{XLEN{((r_op == OP_MULH) || (r_op == OP_MULHSU)) && r_a[XLEN-1]}}, r_a};
  assign w_mb      = {{XLEN{(r_op == OP_MULH) && r_b[XLEN-1]}}, r_b};
  assign w_prod    = w_ma * w_mb;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          if (w_is_mul) w_next = MUL;
`ifdef ALU_DIV_EN
          else if (w_is_div) w_next = DIV;
`endif
          else w_next = DONE;
        end else if ((r_state == DONE) && alu.out_ready) begin
          w_next = IDLE;
        end
      end
      MUL: w_next = DONE;
`ifdef ALU_DIV_EN
      DIV: if (w_last) w_next = DONE;
`else
      DIV: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
    if (alu.flush) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
`ifdef ALU_DIV_EN
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_rem  <= 1'b0;
`endif
    end else if (!alu.flush) begin
      if (w_accept) begin
        r_result  <= w_res;
        r_branch  <= w_br;
        r_illegal <= w_ill;
        r_op      <= alu.op;
        r_a       <= alu.a;
        r_b       <= alu.b;
`ifdef ALU_DIV_EN
        r_dvd     <= w_neg_a ? -alu.a : alu.a;
        r_dvs     <= w_neg_b ? -alu.b : alu.b;
        r_rem     <= '0;
        r_cnt     <= '0;
        r_neg_q   <= w_neg_a ^ w_neg_b;
        r_neg_r   <= w_neg_a;
        r_is_rem  <= (alu.op == OP_REM) || (alu.op == OP_REMU);
`endif
      end else if (r_state == MUL) begin
        r_result <= w_mul_res;
      end
`ifdef ALU_DIV_EN
      else if (r_state == DIV) begin
        r_dvd <= w_q_n;
        r_rem <= w_rem_n;
        r_cnt <= r_cnt + SHW'(1);
        if (w_last) r_result <= w_div_res;
      end
`endif
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed vector bench for multicycle_alu (XLEN=32, honours ALU_DIV_EN)
module tb_multicycle_alu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.XLEN(XLEN)) bus ();
  multicycle_alu #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .alu(bus));

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(string n, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] res, logic br, logic ill, int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res; v.br = br; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic br, output logic ill, output int lat);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 5'(op + 5'd1);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result; br = bus.branch; ill = bus.illegal;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic watch_quiet(string name, int cycles);
    logic rose = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) rose = 1'b1;
    end
    check(name, rose, 0);
  endtask

  logic [31:0] r_res;
  logic r_br, r_ill;
  int r_lat;

  initial begin
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    vecs.push_back(mk("add",    5'd0,  32'd3,        32'd4,        32'd7,        0, 0, 1));
    vecs.push_back(mk("addwrap",5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 1));
    vecs.push_back(mk("sub",    5'd1,  32'd0,        32'd1,        32'hFFFFFFFF, 0, 0, 1));
    vecs.push_back(mk("sll",    5'd2,  32'd1,        32'h23,       32'd8,        0, 0, 1));
    vecs.push_back(mk("slt",    5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 1));
    vecs.push_back(mk("sltu",   5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 1));
    vecs.push_back(mk("xor",    5'd5,  32'hF0F0,     32'hFF00,     32'h0FF0,     0, 0, 1));
    vecs.push_back(mk("srl",    5'd6,  32'h80000000, 32'd31,       32'd1,        0, 0, 1));
    vecs.push_back(mk("sra",    5'd7,  32'h80000000, 32'd4,        32'hF8000000, 0, 0, 1));
    vecs.push_back(mk("or",     5'd8,  32'hA0,       32'h0B,       32'hAB,       0, 0, 1));
    vecs.push_back(mk("and",    5'd9,  32'hFF,       32'h0F,       32'h0F,       0, 0, 1));
    vecs.push_back(mk("beq",    5'd10, 32'd5,        32'd5,        32'd0,        1, 0, 1));
    vecs.push_back(mk("bne",    5'd11, 32'd5,        32'd5,        32'd0,        0, 0, 1));
    vecs.push_back(mk("blt",    5'd12, 32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 1));
    vecs.push_back(mk("bge",    5'd13, 32'hFFFFFFFF, 32'd0,        32'd0,        0, 0, 1));
    vecs.push_back(mk("bltu",   5'd14, 32'hFFFFFFFF, 32'd0,        32'd0,        0, 0, 1));
    vecs.push_back(mk("bgeu",   5'd15, 32'hFFFFFFFF, 32'd0,        32'd0,        1, 0, 1));
    vecs.push_back(mk("jal",    5'd16, 32'h100,      32'd4,        32'h104,      1, 0, 1));
    vecs.push_back(mk("mul",    5'd17, 32'h80000000, 32'h80000000, 32'h0,        0, 0, 2));
    vecs.push_back(mk("mulh",   5'd18, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 2));
    vecs.push_back(mk("mulhu",  5'd20, 32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 2));
    vecs.push_back(mk("mulhsu", 5'd19, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 0, 0, 2));
    vecs.push_back(mk("mul67",  5'd17, 32'd6,        32'd7,        32'd42,       0, 0, 2));
    vecs.push_back(mk("ill26",  5'd26, 32'd9,        32'd9,        32'd0,        0, 1, 1));
    vecs.push_back(mk("ill31",  5'd31, 32'd9,        32'd9,        32'd0,        0, 1, 1));
`ifdef ALU_DIV_EN
    vecs.push_back(mk("div-7/2",5'd21, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 33));
    vecs.push_back(mk("rem-7/2",5'd23, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 33));
    vecs.push_back(mk("divu5/0",5'd22, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 1));
    vecs.push_back(mk("remu5/0",5'd24, 32'd5,        32'd0,        32'd5,        0, 0, 1));
    vecs.push_back(mk("div5/0", 5'd21, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 0, 1));
    vecs.push_back(mk("divovf", 5'd21, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 1));
    vecs.push_back(mk("removf", 5'd23, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0, 1));
    vecs.push_back(mk("divu",   5'd22, 32'd100,      32'd7,        32'd14,       0, 0, 33));
    vecs.push_back(mk("remu",   5'd24, 32'd100,      32'd7,        32'd2,        0, 0, 33));
    vecs.push_back(mk("div7/-2",5'd21, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 0, 0, 33));
    vecs.push_back(mk("rem7/-2",5'd23, 32'd7,        32'hFFFFFFFE, 32'd1,        0, 0, 33));
`else
    vecs.push_back(mk("nodiv21",5'd21, 32'd100,      32'd7,        32'd0,        0, 1, 1));
    vecs.push_back(mk("nodiv22",5'd22, 32'd100,      32'd7,        32'd0,        0, 1, 1));
    vecs.push_back(mk("nodiv23",5'd23, 32'd100,      32'd7,        32'd0,        0, 1, 1));
    vecs.push_back(mk("nodiv24",5'd24, 32'd5,        32'd0,        32'd0,        0, 1, 1));
`endif

    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_branch", bus.branch, 0);
    check("rst_illegal", bus.illegal, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_res, r_br, r_ill, r_lat);
      check({vecs[i].name, "_res"}, r_res, vecs[i].res);
      check({vecs[i].name, "_br"}, r_br, vecs[i].br);
      check({vecs[i].name, "_ill"}, r_ill, vecs[i].ill);
      check({vecs[i].name, "_lat"}, r_lat, vecs[i].lat);
    end

    // Backpressure hold, then back-to-back accept while the held result drains.
    bus.op = 5'd0; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 32'd50;
    check("bp_valid", bus.out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", bus.result, 32'd7);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.op = 5'd3; bus.a = 32'hFFFFFFFF; bus.b = 32'd1;
    #1;
    check("b2b_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_res", bus.result, 32'd1);
    @(posedge clk); #1;
    check("drain_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Flush of a held result.
    bus.op = 5'd0; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_held_valid", bus.out_valid, 0);
    check("flush_held_ready", bus.in_ready, 1);

    // Flush wins over a same-cycle offer.
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    watch_quiet("flush_vs_accept", 4);

    // Flush while a multiply is in flight.
    bus.op = 5'd17; bus.a = 32'd6; bus.b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_mul_ready", bus.in_ready, 1);
    watch_quiet("flush_mul_quiet", 5);

`ifdef ALU_DIV_EN
    bus.op = 5'd22; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("div_busy_ready", bus.in_ready, 0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_div_ready", bus.in_ready, 1);
    watch_quiet("flush_div_quiet", 40);
`endif

    // Asynchronous reset while a result (with branch set) is held.
    bus.op = 5'd16; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("jal_held_res", bus.result, 32'd7);
    check("jal_held_br", bus.branch, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_res", bus.result, 0);
    check("arst_br", bus.branch, 0);
    check("arst_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset during an in-flight long op must produce no output afterwards.
`ifdef ALU_DIV_EN
    bus.op = 5'd22; bus.a = 32'd100; bus.b = 32'd7;
`else
    bus.op = 5'd17; bus.a = 32'd6; bus.b = 32'd7;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
`ifdef ALU_DIV_EN
    repeat (5) begin @(posedge clk); #1; end
`endif
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_res", bus.result, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_quiet("mid_rst_quiet", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, power of two, 8..64.
REQ-002 SHALL have ports `clk` (in, 1) and `rst_n` (in, 1); one clock; reset asynchronous, active-low.
REQ-003 SHALL have ports `in_valid` (in, 1, op offered) and `in_ready` (out, 1, op accepted when both high at rising edge).
REQ-004 SHALL have ports `op` (in, 5, operation code), `a` (in, XLEN, operand 1) and `b` (in, XLEN, operand 2).
REQ-005 SHALL have ports `flush` (in, 1, synchronous abort of in-flight op), `out_valid` (out, 1, result held) and `out_ready` (in, 1, consumer takes result).
REQ-006 SHALL have ports `result` (out, XLEN, op result), `branch` (out, 1, branch predicate) and `illegal` (out, 1, unsupported op code).

Function
REQ-007 SHALL decode op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 BEQ/BNE/BLT/BGE/BLTU/BGEU, 16 JAL, 17-20 MUL/MULH/MULHSU/MULHU, 21-24 DIV/DIVU/REM/REMU; 25-31 illegal.
REQ-008 SHALL use only b[log2(XLEN)-1:0] as shift amount; SRA sign-fills, SRL zero-fills.
REQ-009 SHALL set SLT/SLTU result to zero-extended 1-bit compare; wrap ADD/SUB modulo 2^XLEN.
REQ-010 SHALL set branch ops: result 0, branch = predicate; JAL: result a+b, branch 1; all other ops branch 0.
REQ-011 SHALL treat illegal op as: result 0, branch 0, illegal 1, latency 1; illegal 0 for all legal ops.
REQ-012 SHALL run FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-013 SHALL complete ALU/branch/JAL/illegal ops in latency 1: accept at edge N -> out_valid high after edge N+1 (IDLE->DONE).
REQ-014 SHALL complete MUL ops in latency 2 (IDLE->MUL->DONE); MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of signed*signed / signed*unsigned / unsigned*unsigned 2*XLEN product.
REQ-015 SHALL complete DIV ops by restoring division, one quotient bit per cycle: accept at edge N -> out_valid after edge N+XLEN+1; quotient truncates toward zero; remainder takes sign of a.
REQ-016 SHALL treat divide by zero as: quotient all ones, remainder a, latency 1.
REQ-017 SHALL treat signed overflow (a = most negative, b = -1) as: DIV result a, REM result 0, latency 1.
REQ-018 SHALL drive in_ready high in IDLE, and in DONE when out_ready is high (back-to-back, no bubble); low in MUL and DIV.
REQ-019 SHALL hold result, branch, illegal stable while out_valid high and out_ready low.
REQ-020 SHALL on out_valid&out_ready without a new accept: DONE->IDLE, out_valid low next cycle.
REQ-021 SHALL on flush high at an edge: force IDLE, out_valid 0, discard in-flight and held results, ignore same-cycle in_valid; flush has priority over every other event.
REQ-022 SHALL sample op/a/b only at accept; later input changes SHALL not affect the in-flight op.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of clock: state IDLE, out_valid 0, result 0, branch 0, illegal 0, divider/multiplier registers 0.
REQ-024 SHALL drive in_ready 1 while in reset and on the first edge after release; reset during DIV/MUL SHALL abort with no output.

Configuration
REQ-025 SHALL include the iterative divider and DIV state when macro ALU_DIV_EN is defined.
REQ-026 SHALL without ALU_DIV_EN treat ops 21-24 as illegal per REQ-011 (result 0, illegal 1, latency 1), with no divider logic synthesised.

Verification (XLEN=32, ALU_DIV_EN defined unless stated)
REQ-027 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD after 33 edges; REM same operands -> 0xFFFFFFFF.
REQ-028 SHALL cover: MULH a=b=0x80000000 -> 0x40000000 at latency 2; MULHU same -> 0x40000000; MUL same -> 0x00000000.
REQ-029 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x00000005 at latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-030 SHALL cover: ADD 3+4, out_ready low 3 cycles -> result 0x00000007 held stable, in_ready low; out_ready high with new SLT(-1,1) valid -> next result 0x00000001, no bubble.
REQ-031 SHALL cover: flush at cycle 10 of DIVU 100/7 -> out_valid never rises, in_ready 1 next cycle; rst_n low mid-divide -> all outputs 0 immediately.
REQ-032 SHALL cover: op 26 -> illegal 1, result 0; without ALU_DIV_EN, op 21 -> illegal 1, result 0, latency 1.
